// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// One request is outstanding at a time; the address is held stable until ack.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues one imem request at a time and hands
// {inst, pc, valid} to ID, buffering one response while ID stalls.
//
// state | meaning
// ------+------------------------------------------------------------------
// REQ   | request at pc_f is up; its response is delivered, held or dropped
// HOLD  | response parked in hold regs while ID stalls; no request up
// DROP  | wrong-path request at drop_addr still in flight; response discarded
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            npc,
    input  logic                   redirect,
    input  logic                   stall_d,
    output logic [31:0]            pc_plus4,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            inst_d,
    output logic [31:0]            pc_d,
    output logic                   valid_d
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_f;
    logic [31:0] pc_f_nxt;
    logic [31:0] hold_inst;
    logic [31:0] hold_inst_nxt;
    logic [31:0] hold_pc;
    logic [31:0] hold_pc_nxt;
    logic [31:0] drop_addr;
    logic [31:0] drop_addr_nxt;
    logic [31:0] inst_d_nxt;
    logic [31:0] pc_d_nxt;
    logic        valid_d_nxt;

    logic        deliver;
    logic [31:0] deliver_inst;
    logic [31:0] deliver_pc;
    logic        req_c;
    logic [31:0] npc_aligned;

    assign npc_aligned   = npc & ~32'h3;
    assign pc_plus4      = pc_f + 32'd4;
    // the memory is reset by the same rst, so no request may be seen during it
    assign imem.imem_req = req_c & ~rst;

    always_comb begin
        state_nxt      = state;
        pc_f_nxt       = pc_f;
        hold_inst_nxt  = hold_inst;
        hold_pc_nxt    = hold_pc;
        drop_addr_nxt  = drop_addr;
        deliver        = 1'b0;
        deliver_inst   = hold_inst;
        deliver_pc     = hold_pc;
        req_c          = 1'b0;
        imem.imem_addr = pc_f;

        case (state)
            S_REQ: begin
                req_c          = 1'b1;
                imem.imem_addr = pc_f;
                if (imem.imem_ack) begin
                    pc_f_nxt = npc_aligned;
                    if (!redirect) begin
                        if (!stall_d) begin
                            deliver      = 1'b1;
                            deliver_inst = imem.imem_rdata;
                            deliver_pc   = pc_f;
                        end else begin
                            hold_inst_nxt = imem.imem_rdata;
                            hold_pc_nxt   = pc_f;
                            state_nxt     = S_HOLD;
                        end
                    end
                end else if (redirect) begin
                    drop_addr_nxt = pc_f;
                    pc_f_nxt      = npc_aligned;
                    state_nxt     = S_DROP;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_f_nxt  = npc_aligned;
                    state_nxt = S_REQ;
                end else if (!stall_d) begin
                    deliver   = 1'b1;
                    state_nxt = S_REQ;
                end
            end

            S_DROP: begin
                req_c          = 1'b1;
                imem.imem_addr = drop_addr;
                if (redirect) begin
                    pc_f_nxt = npc_aligned;
                end
                if (imem.imem_ack) begin
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase

        // redirect kills whatever ID holds, even under stall
        inst_d_nxt  = inst_d;
        pc_d_nxt    = pc_d;
        valid_d_nxt = valid_d;
        if (redirect) begin
            valid_d_nxt = 1'b0;
        end else if (deliver) begin
            inst_d_nxt  = deliver_inst;
            pc_d_nxt    = deliver_pc;
            valid_d_nxt = 1'b1;
        end else if (!stall_d) begin
            valid_d_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc_f      <= RESET_PC & ~32'h3;
            hold_inst <= 32'h0;
            hold_pc   <= 32'h0;
            drop_addr <= 32'h0;
            inst_d    <= 32'h0;
            pc_d      <= 32'h0;
            valid_d   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc_f      <= pc_f_nxt;
            hold_inst <= hold_inst_nxt;
            hold_pc   <= hold_pc_nxt;
            drop_addr <= drop_addr_nxt;
            inst_d    <= inst_d_nxt;
            pc_d      <= pc_d_nxt;
            valid_d   <= valid_d_nxt;
        end
    end

endmodule
